// File: rtl/hazard_forward_unit_if.sv
// Bus between the pipeline's ID stage and the hazard/forwarding unit.
// The master is the pipeline datapath and the slave is the hazard/forwarding unit.
interface hazard_forward_unit_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
);
  logic                ID_Valid;
  logic [REG_BITS-1:0] ID_Rs;
  logic [REG_BITS-1:0] ID_Rt;
  logic                ID_UsesRs;
  logic                ID_UsesRt;
  logic [REG_BITS-1:0] ID_WriteReg;
  logic                ID_RegWrite;
  logic                ID_MemRead;
  logic                Flush;
  logic [1:0]          ForwardA;
  logic [1:0]          ForwardB;
  logic                Stall;
  logic                PCWrite;
  logic                IFID_Write;
  logic                IDEX_Bubble;
  logic [CNT_BITS-1:0] StallCount;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
           ID_WriteReg, ID_RegWrite, ID_MemRead, Flush,
    input  ForwardA, ForwardB, Stall, PCWrite, IFID_Write,
           IDEX_Bubble, StallCount
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
           ID_WriteReg, ID_RegWrite, ID_MemRead, Flush,
    output ForwardA, ForwardB, Stall, PCWrite, IFID_Write,
           IDEX_Bubble, StallCount
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall and EX operand forwarding control for the 5-stage MIPS core.
// It shadows destination-register info for EX and MEM and registers the forward selects.
module hazard_forward_unit #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_unit_if.slave hz
);

  typedef struct packed {
    logic [REG_BITS-1:0] dst;
    logic                wr;
    logic                ld;
  } ex_info_t;

  // The unit never inspects WB, because the register file writes before it reads.
  // MEM therefore needs no load flag.
  typedef struct packed {
    logic [REG_BITS-1:0] dst;
    logic                wr;
  } mem_info_t;

  ex_info_t            ex_q;
  mem_info_t           mem_q;
  logic [1:0]          fwd_a_q;
  logic [1:0]          fwd_b_q;
  logic [CNT_BITS-1:0] stall_cnt_q;

  logic       stall;
  logic       kill;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // The younger producer wins. A load still in EX cannot forward, and the stall covers it.
  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src,
                                         input logic                uses,
                                         input ex_info_t            ex,
                                         input mem_info_t           mem);
    fwd_sel = 2'b00;
    if (uses && src != '0) begin
      if (ex.wr && !ex.ld && ex.dst == src)
        fwd_sel = 2'b10;
      else if (mem.wr && mem.dst == src)
        fwd_sel = 2'b01;
    end
  endfunction

  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    stall = 1'b0;
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (hz.ID_Valid && !hz.Flush && ex_q.wr && ex_q.ld && ex_q.dst != '0)
      stall = (hz.ID_UsesRs && hz.ID_Rs == ex_q.dst) ||
              (hz.ID_UsesRt && hz.ID_Rt == ex_q.dst);
    sel_a = fwd_sel(hz.ID_Rs, hz.ID_UsesRs, ex_q, mem_q);
    sel_b = fwd_sel(hz.ID_Rt, hz.ID_UsesRt, ex_q, mem_q);
  end

  assign kill = stall || hz.Flush || !hz.ID_Valid;

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      mem_q.dst <= ex_q.dst;
      mem_q.wr  <= ex_q.wr;
      if (kill) begin
        ex_q    <= '0;
        fwd_a_q <= 2'b00;
        fwd_b_q <= 2'b00;
      end else begin
        ex_q.dst <= hz.ID_WriteReg;
        ex_q.wr  <= hz.ID_RegWrite;
        ex_q.ld  <= hz.ID_MemRead;
        fwd_a_q  <= sel_a;
        fwd_b_q  <= sel_b;
      end
      if (stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign hz.Stall       = stall;
  assign hz.PCWrite     = !stall;
  assign hz.IFID_Write  = !stall;
  // While reset is held, the bubble stays low even if Flush is high.
  assign hz.IDEX_Bubble = reset && (stall || hz.Flush);
  assign hz.ForwardA    = fwd_a_q;
  assign hz.ForwardB    = fwd_b_q;
  assign hz.StallCount  = stall_cnt_q;

endmodule
